// File: rtl/register_file.sv
// Two-read/one-write register file with hardwired-zero x0 and async active-low reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module register_file #(
    parameter int unsigned           ADDR_WIDTH  = 5,
    parameter logic [`DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  rs1_addr,
    input  logic [ADDR_WIDTH-1:0]  rs2_addr,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [`DATA_WIDTH-1:0] rd_data,
    input  logic                   reg_write,
    output logic [`DATA_WIDTH-1:0] rs1_data,
    output logic [`DATA_WIDTH-1:0] rs2_data
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    // x0 has no storage; entries start at index 1
    logic [`DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

    logic write_en;
    assign write_en = reg_write && (rd_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: RESET_VALUE};
        end else if (write_en) begin
            regs[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = regs[rs1_addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (rst_n && write_en && (rd_addr == rs1_addr)) begin
            rs1_data = rd_data;
        end
`endif
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_data = regs[rs2_addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (rst_n && write_en && (rd_addr == rs2_addr)) begin
            rs2_data = rd_data;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed checks of register_file against an array-based reference model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_register_file;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = `DATA_WIDTH;
    localparam int unsigned NR = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [DW-1:0] rd_data;
    logic          reg_write;
    logic [DW-1:0] rs1_data, rs2_data;

    logic [DW-1:0] model [NR];
    int unsigned   total  = 0;
    int unsigned   passed = 0;

    register_file #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .reg_write(reg_write),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    always #50 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rst_n && reg_write && rd_addr == a) return rd_data;
`endif
        return model[a];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_ports(input string tag);
        chk({tag, "_rs1"}, rs1_data, exp_read(rs1_addr));
        chk({tag, "_rs2"}, rs2_data, exp_read(rs2_addr));
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        reg_write = we;
        rd_addr   = rd;
        rd_data   = d;
        rs1_addr  = a1;
        rs2_addr  = a2;
    endtask

    // Advance through one rising edge, applying the write rule to the model
    task automatic tick();
        @(posedge clk);
        if (rst_n && reg_write && rd_addr != '0) model[rd_addr] = rd_data;
        #1;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < NR; a++) begin
            rs1_addr = AW'(a);
            rs2_addr = AW'(NR - 1 - a);
            #1;
            chk_ports(tag);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        model_reset();

        // Reset state, with a write requested while reset is held
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h1234_5678, 5'd4, 5'd0);
        read_all("reset_state");
        drive(1'b1, 5'd4, 32'h1234_5678, 5'd4, 5'd4);
        tick();
        chk_ports("write_in_reset");

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
        tick();
        drive(1'b0, '0, '0, 5'd5, 5'd5);
        #1;
        chk("x5_rs1", rs1_data, 32'hDEAD_BEEF);
        chk("x5_rs2", rs2_data, 32'hDEAD_BEEF);

        @(negedge clk);
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1;
        chk("x0_pre_rs1", rs1_data, '0);
        tick();
        chk("x0_post_rs1", rs1_data, '0);
        chk("x0_post_rs2", rs2_data, '0);

        @(negedge clk);
        drive(1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
        tick();
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h2, 5'd0, 5'd7);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("hazard_pre", rs2_data, 32'h2);
`else
        chk("hazard_pre", rs2_data, 32'h1);
`endif
        tick();
        chk("hazard_post", rs2_data, 32'h2);

        @(negedge clk);
        drive(1'b0, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3);
        tick();
        chk("disabled_x3", rs1_data, '0);

        @(negedge clk);
        drive(1'b1, 5'd9, 32'h10, 5'd9, 5'd9);
        tick();
        chk("x9_first", rs1_data, 32'h10);

        // Reset lands mid-cycle while a write of x9 is pending
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h20, 5'd9, 5'd9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_x9", rs1_data, '0);
        read_all("rst_mid_all");
        drive(1'b1, 5'd9, 32'h20, 5'd9, 5'd9);
        tick();
        chk("rst_held_x9", rs2_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd9, 32'h30, 5'd9, 5'd9);
        tick();
        drive(1'b0, '0, '0, 5'd9, 5'd9);
        #1;
        chk("x9_after_rel", rs1_data, 32'h30);
        chk("x9_after_rel2", rs2_data, 32'h30);

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] rd, a1, a2;
            @(negedge clk);
            rd = AW'($urandom_range(0, NR - 1));
            a1 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NR - 1));
            a2 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NR - 1));
            if ($urandom_range(0, 7) == 0) a2 = a1;
            drive(($urandom_range(0, 9) < 7), rd, DW'($urandom), a1, a2);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                chk_ports("rand_rst");
                #2;
                rst_n = 1'b1;
            end
            #1;
            chk_ports("rand_pre");
            tick();
            chk_ports("rand_post");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
